writeback_stage: RTL and testbench

//  Final pipeline stage of the core, directly upstream of the register file's write port.
//  - Registers the memory-stage result.
//  - Aligns and sign/zero-extends load data.
//  - Selects the write-back source and drives a one-shot we/addr/data triple into the regfile.
//  - Exposes the same triple as a forwarding source.
//  - Counts retired instructions.

---
 rtl/writeback_stage.sv | 73 +++++++
 tb/tb_writeback_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: registers the memory-stage result, aligns load data and drives one regfile write per instruction.
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     mem_valid_i,
  input  logic                     mem_we_i,
  input  logic [ADDR_WIDTH-1:0]    mem_rd_addr_i,
  input  logic [1:0]               mem_sel_i,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result_i,
  input  logic [DATA_WIDTH-1:0]    mem_pc_plus4_i,
  input  logic [DATA_WIDTH-1:0]    mem_csr_data_i,
  input  logic [DATA_WIDTH-1:0]    mem_load_word_i,
  input  logic [1:0]               mem_load_size_i,
  input  logic                     mem_load_unsigned_i,
  input  logic [1:0]               mem_addr_lo_i,
  output logic                     rf_we_o,
  output logic [ADDR_WIDTH-1:0]    rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]    rf_data_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);
  logic                     valid_q, done_q, we_q;
  logic [ADDR_WIDTH-1:0]    rd_q;
  logic [DATA_WIDTH-1:0]    data_q, shifted, load_data, wb_data;
  logic [INSTRET_WIDTH-1:0] instret_q;
  logic [7:0]               byte_lane;
  logic [15:0]              half_lane;
  always_comb begin
    shifted   = mem_load_word_i >> {mem_addr_lo_i, 3'b000};
    byte_lane = shifted[7:0];
    half_lane = mem_addr_lo_i[1] ? mem_load_word_i[31:16] : mem_load_word_i[15:0];
    load_data = mem_load_size_i == 2'd0 ? {{(DATA_WIDTH-8){byte_lane[7] & ~mem_load_unsigned_i}}, byte_lane} :
                mem_load_size_i == 2'd1 ? {{(DATA_WIDTH-16){half_lane[15] & ~mem_load_unsigned_i}}, half_lane} :
                mem_load_word_i;
    wb_data   = mem_sel_i == 2'd0 ? mem_alu_result_i :
                mem_sel_i == 2'd1 ? load_data :
                mem_sel_i == 2'd2 ? mem_pc_plus4_i : mem_csr_data_i;
  end
  // done_q marks a stalled instruction that has already written and retired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      if (valid_q && !done_q) instret_q <= instret_q + 1'b1;
      if (flush_i) begin
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end else if (stall_i) begin
        if (valid_q) done_q <= 1'b1;
      end else begin
        valid_q <= mem_valid_i;
        we_q    <= mem_we_i;
        rd_q    <= mem_rd_addr_i;
        data_q  <= wb_data;
        done_q  <= 1'b0;
      end
    end
  end
  assign rf_we_o         = valid_q & we_q & (|rd_q) & ~done_q;
  assign rf_write_addr_o = rd_q;
  assign rf_data_o       = data_q;
  assign instret_o       = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus checked every cycle against a retirement-level model of the stage.
module tb_writeback_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        mem_valid = 1'b0, mem_we = 1'b0, uns = 1'b0;
  logic [4:0]  rd = '0;
  logic [1:0]  sel = '0, size = 2'd2, lo = '0;
  logic [31:0] alu = '0, pc4 = '0, csr = '0, word = '0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [63:0] instret;
  int checks = 0, errors = 0;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_rd_addr_i(rd), .mem_sel_i(sel),
    .mem_alu_result_i(alu), .mem_pc_plus4_i(pc4), .mem_csr_data_i(csr),
    .mem_load_word_i(word), .mem_load_size_i(size), .mem_load_unsigned_i(uns),
    .mem_addr_lo_i(lo), .rf_we_o(rf_we), .rf_write_addr_o(rf_addr),
    .rf_data_o(rf_data), .instret_o(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [1:0] s, input logic [31:0] a, p, c, w,
                                           input logic [1:0] sz, input logic u, input logic [1:0] l);
    longint unsigned v;
    if (s == 0) return a;
    if (s == 2) return p;
    if (s == 3) return c;
    if (sz == 0) begin
      v = (longint'(w) / (longint'(1) << (8 * l))) % 256;
      return (!u && v >= 128) ? 32'(v + 64'hFFFF_FF00) : 32'(v);
    end
    if (sz == 1) begin
      v = (l >= 2) ? longint'(w) / 65536 : longint'(w) % 65536;
      return (!u && v >= 32768) ? 32'(v + 64'hFFFF_0000) : 32'(v);
    end
    return w;
  endfunction

  // Model: the resident instruction and whether it has already retired
  logic        m_valid = 1'b0, m_retired = 1'b0, m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  logic [63:0] m_count = '0, m_base = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_retired <= 0; m_we <= 0; m_rd <= 0; m_data <= 0; m_count <= 0;
    end else begin
      if (m_valid && !m_retired) m_count <= m_count + 1;
      if (flush) begin
        m_valid <= 0; m_retired <= 0;
      end else if (stall) begin
        if (m_valid) m_retired <= 1;
      end else begin
        m_valid <= mem_valid; m_we <= mem_we; m_rd <= rd; m_retired <= 0;
        m_data <= ref_data(sel, alu, pc4, csr, word, size, uns, lo);
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_we", rf_we, m_valid && !m_retired && m_we && m_rd != 0);
    chk("cmp_addr", rf_addr, m_rd);
    chk("cmp_data", rf_data, m_data);
    chk("cmp_instret", instret, m_count + m_base);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; mem_we = 0;
  endtask

  task automatic send(input logic w, input logic [4:0] r, input logic [1:0] s, input logic [31:0] v,
                      input logic [1:0] sz = 2'd2, input logic u = 1'b0, input logic [1:0] l = 2'd0);
    mem_valid = 1; mem_we = w; rd = r; sel = s; size = sz; uns = u; lo = l;
    alu = 32'hA1A1_0001; word = 32'hB2B2_0002; pc4 = 32'hC3C3_0003; csr = 32'hD4D4_0004;
    case (s)
      2'd0: alu = v;
      2'd1: word = v;
      2'd2: pc4 = v;
      default: csr = v;
    endcase
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_instret", instret, 0);
    rst_n = 1;
    cyc();
    send(1, 5, 0, 32'h1234_5678); cyc();
    chk("alu_we", rf_we, 1);
    chk("alu_addr", rf_addr, 5);
    chk("alu_data", rf_data, 32'h1234_5678);
    idle(); cyc();
    chk("alu_instret", instret, 1);
    send(1, 6, 1, 32'h80FF_7F01, 2'd0, 1'b0, 2'd1); cyc();
    chk("lb_lo1", rf_data, 32'h0000_007F);
    send(1, 6, 1, 32'h80FF_7F01, 2'd0, 1'b0, 2'd3); cyc();
    chk("lb_lo3", rf_data, 32'hFFFF_FF80);
    send(1, 6, 1, 32'h80FF_7F01, 2'd1, 1'b1, 2'd2); cyc();
    chk("lhu_lo2", rf_data, 32'h0000_80FF);
    send(1, 0, 0, 32'h0000_DEAD); cyc();
    chk("x0_we", rf_we, 0);
    send(1, 1, 2, 32'h0000_0104); cyc();
    chk("link_we", rf_we, 1);
    chk("link_data", rf_data, 32'h0000_0104);
    send(1, 2, 3, 32'h0BAD_F00D); cyc();
    chk("csr_data", rf_data, 32'h0BAD_F00D);
    send(1, 7, 0, 32'h0000_CAFE); cyc();
    chk("stall_first_we", rf_we, 1);
    stall = 1;
    send(1, 9, 0, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_we", rf_we, 0);
      chk("stall_addr", rf_addr, 7);
      chk("stall_data", rf_data, 32'h0000_CAFE);
    end
    stall = 0; idle(); cyc();
    chk("stall_instret", instret, 8);
    send(1, 8, 0, 32'h0000_8888); flush = 1; cyc();
    chk("flush_we", rf_we, 0);
    flush = 0;
    send(1, 9, 0, 32'h0000_9999); cyc();
    chk("pre_flush_we", rf_we, 1);
    stall = 1; flush = 1; cyc();
    chk("flush_stall_we", rf_we, 0);
    flush = 0; cyc();
    chk("empty_we", rf_we, 0);
    stall = 0; idle(); cyc();
    chk("flush_instret", instret, 9);
    send(1, 10, 0, 32'h0000_0055); cyc();
    stall = 1; cyc();
    #2 rst_n = 0;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_addr", rf_addr, 0);
    chk("arst_data", rf_data, 0);
    chk("arst_instret", instret, 0);
    cyc();
    rst_n = 1; stall = 0; idle();
    cyc();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    m_base = 64'hFFFF_FFFF_FFFF_FFFE - m_count;
    #1 release dut.instret_q;
    send(1, 11, 0, 32'h0000_0011); cyc();
    send(1, 12, 0, 32'h0000_0012); cyc();
    chk("wrap_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(); cyc();
    chk("wrap_zero", instret, 0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
